// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the 1-cycle-latency instruction SRAM
// and presents a valid/ready stream of {pc, inst, address-error} to decode.
//
// state | meaning
// BOOT  | first cycle after reset release; RESET_PC issued, nothing presented
// RUN   | a request is in flight and its result is presented to decode
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        f_valid,
  input  logic        f_ready,
  output logic [31:0] f_pc,
  output logic [31:0] f_inst,
  output logic        f_exc_adel,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_adel;
  logic [31:0] next_pc;
  logic        fire;
  logic        stall;

  assign req_valid = (state == RUN);

  assign f_valid    = req_valid & ~redirect_valid;
  assign f_pc       = req_pc;
  assign f_inst     = req_adel ? 32'h0 : inst_sram_rdata;
  assign f_exc_adel = req_adel;

  assign fire  = f_valid & f_ready;
  assign stall = f_valid & ~f_ready;

  // A stalled request re-issues its own address so rdata stays valid without a holding buffer.
  always_comb begin
    next_pc = req_pc;
    if (redirect_valid)  next_pc = redirect_pc;
    else if (!req_valid) next_pc = RESET_PC;
    else if (fire)       next_pc = req_pc + STEP;
  end

  assign inst_sram_addr  = next_pc;
  assign inst_sram_en    = resetn & (next_pc[1:0] == 2'b00);
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= BOOT;
      req_pc       <= RESET_PC;
      req_adel     <= 1'b0;
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      state    <= RUN;
      req_pc   <= next_pc;
      req_adel <= (next_pc[1:0] != 2'b00);
      if (fire)  perf_fetched <= perf_fetched + 32'd1;
      if (stall) perf_stall   <= perf_stall + 32'd1;
    end
  end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Bench for inst_fetch_stage: SRAM model, per-cycle behavioural model compare, and directed literal checks.
module tb_inst_fetch_stage;

  localparam logic [31:0] RST_PC = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        f_valid;
  logic        f_ready;
  logic [31:0] f_pc;
  logic [31:0] f_inst;
  logic        f_exc_adel;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch_stage #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc), .f_inst(f_inst),
    .f_exc_adel(f_exc_adel), .perf_fetched(perf_fetched), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  // Synchronous-read SRAM: data for the address enabled on the previous edge.
  always @(posedge clk) if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: what decode should see, derived from the fetch rules.
  bit          m_busy;
  logic [31:0] m_pc;
  logic [31:0] m_fetched;
  logic [31:0] m_stall;
  logic [31:0] e_next = RST_PC;
  bit          e_acc = 0;
  bit          e_stl = 0;

  always @(negedge clk) begin
    bit e_valid;
    bit e_adel;
    e_valid = resetn && m_busy && !redirect_valid;
    e_adel  = (m_pc[1:0] != 2'b00);
    if (redirect_valid)  e_next = redirect_pc;
    else if (!m_busy)    e_next = RST_PC;
    else if (f_ready)    e_next = m_pc + 32'd4;
    else                 e_next = m_pc;
    e_acc = e_valid && f_ready;
    e_stl = e_valid && !f_ready;
    chk("cmp_f_valid", {31'h0, f_valid}, {31'h0, e_valid});
    chk("cmp_addr", inst_sram_addr, e_next);
    chk("cmp_en", {31'h0, inst_sram_en}, {31'h0, resetn && (e_next[1:0] == 2'b00)});
    chk("cmp_wen", {28'h0, inst_sram_wen}, 32'h0);
    chk("cmp_wdata", inst_sram_wdata, 32'h0);
    chk("cmp_perf_fetched", perf_fetched, m_fetched);
    chk("cmp_perf_stall", perf_stall, m_stall);
    if (e_valid) begin
      chk("cmp_f_pc", f_pc, m_pc);
      chk("cmp_f_adel", {31'h0, f_exc_adel}, {31'h0, e_adel});
      chk("cmp_f_inst", f_inst, e_adel ? 32'h0 : mem_word(m_pc));
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy    <= 0;
      m_pc      <= RST_PC;
      m_fetched <= 32'h0;
      m_stall   <= 32'h0;
    end else begin
      m_busy    <= 1;
      m_pc      <= e_next;
      m_fetched <= m_fetched + (e_acc ? 32'd1 : 32'd0);
      m_stall   <= m_stall + (e_stl ? 32'd1 : 32'd0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; f_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_f_valid", {31'h0, f_valid}, 32'h0);
    chk("rst_en", {31'h0, inst_sram_en}, 32'h0);
    chk("rst_addr", inst_sram_addr, 32'hbfc0_0000);
    chk("rst_perf_fetched", perf_fetched, 32'h0);

    // Boot and stream with f_ready held high
    cyc(); resetn = 1'b1; f_ready = 1'b1;
    smp();
    chk("boot_addr", inst_sram_addr, 32'hbfc0_0000);
    chk("boot_f_valid", {31'h0, f_valid}, 32'h0);
    chk("boot_en", {31'h0, inst_sram_en}, 32'h1);
    cyc(); smp();
    chk("s0_f_pc", f_pc, 32'hbfc0_0000);
    chk("s0_f_inst", f_inst, 32'hadf4_5678);
    chk("s0_addr", inst_sram_addr, 32'hbfc0_0004);
    cyc(); smp();
    chk("s1_f_pc", f_pc, 32'hbfc0_0004);
    chk("s1_addr", inst_sram_addr, 32'hbfc0_0008);
    cyc(); smp();
    chk("s2_f_pc", f_pc, 32'hbfc0_0008);

    // Three stall cycles presenting bfc0000c
    cyc(); f_ready = 1'b0;
    smp();
    chk("st_perf_fetched", perf_fetched, 32'd3);
    chk("st_f_pc", f_pc, 32'hbfc0_000c);
    chk("st_addr", inst_sram_addr, 32'hbfc0_000c);
    cyc(); smp();
    chk("st_f_inst", f_inst, 32'hadf4_5674);
    cyc(); smp();
    cyc(); f_ready = 1'b1;
    smp();
    chk("st_perf_stall", perf_stall, 32'd3);
    chk("st_rel_f_pc", f_pc, 32'hbfc0_000c);
    chk("st_rel_addr", inst_sram_addr, 32'hbfc0_0010);
    cyc(); smp();
    chk("st_after_f_pc", f_pc, 32'hbfc0_0010);

    // Redirect collides with f_ready
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
    smp();
    chk("rd_f_valid", {31'h0, f_valid}, 32'h0);
    chk("rd_addr", inst_sram_addr, 32'h8000_1000);
    cyc(); redirect_valid = 1'b0;
    smp();
    chk("rd_f_pc", f_pc, 32'h8000_1000);
    chk("rd_perf_fetched", perf_fetched, 32'd5);

    // Misaligned target, held under stall, then sequential continuation
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h8000_1002;
    smp();
    chk("mis_en", {31'h0, inst_sram_en}, 32'h0);
    cyc(); redirect_valid = 1'b0; f_ready = 1'b0;
    smp();
    chk("mis_f_valid", {31'h0, f_valid}, 32'h1);
    chk("mis_adel", {31'h0, f_exc_adel}, 32'h1);
    chk("mis_f_inst", f_inst, 32'h0);
    cyc(); smp();
    chk("mis_hold_pc", f_pc, 32'h8000_1002);
    cyc(); f_ready = 1'b1;
    smp();
    chk("mis_next_addr", inst_sram_addr, 32'h8000_1006);
    cyc(); smp();
    chk("mis_next_pc", f_pc, 32'h8000_1006);

    // Back-to-back redirects: only the last target is fetched
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
    cyc(); redirect_pc = 32'h8000_3000;
    smp();
    chk("b2b_addr", inst_sram_addr, 32'h8000_3000);
    cyc(); redirect_valid = 1'b0;
    smp();
    chk("b2b_f_pc", f_pc, 32'h8000_3000);

    // PC wrap past the top of the address space
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'hffff_fffc;
    cyc(); redirect_valid = 1'b0;
    smp();
    chk("wrap_f_pc0", f_pc, 32'hffff_fffc);
    chk("wrap_addr", inst_sram_addr, 32'h0000_0000);
    cyc(); smp();
    chk("wrap_f_pc1", f_pc, 32'h0000_0000);

    // Asynchronous reset in the middle of a stall
    cyc(); f_ready = 1'b0;
    smp();
    chk("mr_pre_valid", {31'h0, f_valid}, 32'h1);
    #2; resetn = 1'b0;
    #1;
    chk("mr_f_valid", {31'h0, f_valid}, 32'h0);
    chk("mr_en", {31'h0, inst_sram_en}, 32'h0);
    chk("mr_perf_fetched", perf_fetched, 32'h0);
    chk("mr_perf_stall", perf_stall, 32'h0);
    cyc(); cyc(); resetn = 1'b1; f_ready = 1'b1;
    smp();
    chk("mr_boot_addr", inst_sram_addr, 32'hbfc0_0000);
    cyc(); smp();
    chk("mr_f_pc", f_pc, 32'hbfc0_0000);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
